// File: rtl/led_timer_core_if.sv
// Control/status bundle between the LED_Timer register block (master)
// and the timing engine (slave).
interface led_timer_core_if #(
   parameter int unsigned NUM_LEDS  = 8,
   parameter int unsigned CNT_WIDTH = 16
);
   logic                 start;
   logic                 stop;
   logic                 oneshot;
   logic [CNT_WIDTH-1:0] prescale;
   logic [CNT_WIDTH-1:0] on_ticks;
   logic [CNT_WIDTH-1:0] off_ticks;
   logic [7:0]           blink_count;
   logic [NUM_LEDS-1:0]  pattern;
   logic [NUM_LEDS-1:0]  led;
   logic                 busy;
   logic                 done;
   logic [7:0]           blinks_done;

   modport master (
      output start, stop, oneshot, prescale, on_ticks, off_ticks,
             blink_count, pattern,
      input  led, busy, done, blinks_done
   );

   modport slave (
      input  start, stop, oneshot, prescale, on_ticks, off_ticks,
             blink_count, pattern,
      output led, busy, done, blinks_done
   );
endinterface

// File: rtl/led_timer_core.sv
// LED blink timing engine: prescaled tick drives an IDLE/ON/OFF sequencer
// using shadowed copies of the configuration latched at start.
module led_timer_core #(
   parameter int unsigned NUM_LEDS  = 8,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic             ACLK,
   input  logic             ARESET,
   led_timer_core_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_LEDS-1:0]  led_q, led_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [7:0]           blinks_done_q, blinks_done_d;
   logic [CNT_WIDTH-1:0] prescale_cnt_q, prescale_cnt_d;
   logic [CNT_WIDTH-1:0] phase_cnt_q, phase_cnt_d;

   logic                 oneshot_l_q, oneshot_l_d;
   logic [CNT_WIDTH-1:0] prescale_l_q, prescale_l_d;
   logic [CNT_WIDTH-1:0] on_ticks_l_q, on_ticks_l_d;
   logic [CNT_WIDTH-1:0] off_ticks_l_q, off_ticks_l_d;
   logic [7:0]           blink_count_l_q, blink_count_l_d;
   logic [NUM_LEDS-1:0]  pattern_l_q, pattern_l_d;

   logic                 tick;
   logic [7:0]           blinks_next;

   always_comb begin
      state_d         = state_q;
      done_d          = 1'b0;
      blinks_done_d   = blinks_done_q;
      prescale_cnt_d  = prescale_cnt_q;
      phase_cnt_d     = phase_cnt_q;
      oneshot_l_d     = oneshot_l_q;
      prescale_l_d    = prescale_l_q;
      on_ticks_l_d    = on_ticks_l_q;
      off_ticks_l_d   = off_ticks_l_q;
      blink_count_l_d = blink_count_l_q;
      pattern_l_d     = pattern_l_q;
      tick            = (prescale_cnt_q == prescale_l_q);
      blinks_next     = blinks_done_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.stop) begin
               oneshot_l_d     = bus.oneshot;
               prescale_l_d    = bus.prescale;
               on_ticks_l_d    = bus.on_ticks;
               off_ticks_l_d   = bus.off_ticks;
               blink_count_l_d = bus.blink_count;
               pattern_l_d     = bus.pattern;
               prescale_cnt_d  = '0;
               phase_cnt_d     = '0;
               blinks_done_d   = '0;
               state_d         = S_ON;
            end
         end
         S_ON: begin
            if (tick) begin
               prescale_cnt_d = '0;
               if (phase_cnt_q == on_ticks_l_q) begin
                  phase_cnt_d = '0;
                  state_d     = S_OFF;
               end else begin
                  phase_cnt_d = phase_cnt_q + 1'b1;
               end
            end else begin
               prescale_cnt_d = prescale_cnt_q + 1'b1;
            end
         end
         S_OFF: begin
            if (tick) begin
               prescale_cnt_d = '0;
               if (phase_cnt_q == off_ticks_l_q) begin
                  phase_cnt_d   = '0;
                  blinks_done_d = blinks_next;
                  // 8-bit wrap makes blink_count 0 match after the 256th blink
                  if (oneshot_l_q && (blinks_next == blink_count_l_q)) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_ON;
                  end
               end else begin
                  phase_cnt_d = phase_cnt_q + 1'b1;
               end
            end else begin
               prescale_cnt_d = prescale_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.stop) begin
         state_d       = S_IDLE;
         done_d        = 1'b0;
         blinks_done_d = blinks_done_q;
      end

      led_d  = (state_d == S_ON) ? pattern_l_d : '0;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q         <= S_IDLE;
         led_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         blinks_done_q   <= '0;
         prescale_cnt_q  <= '0;
         phase_cnt_q     <= '0;
         oneshot_l_q     <= 1'b0;
         prescale_l_q    <= '0;
         on_ticks_l_q    <= '0;
         off_ticks_l_q   <= '0;
         blink_count_l_q <= '0;
         pattern_l_q     <= '0;
      end else begin
         state_q         <= state_d;
         led_q           <= led_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         blinks_done_q   <= blinks_done_d;
         prescale_cnt_q  <= prescale_cnt_d;
         phase_cnt_q     <= phase_cnt_d;
         oneshot_l_q     <= oneshot_l_d;
         prescale_l_q    <= prescale_l_d;
         on_ticks_l_q    <= on_ticks_l_d;
         off_ticks_l_q   <= off_ticks_l_d;
         blink_count_l_q <= blink_count_l_d;
         pattern_l_q     <= pattern_l_d;
      end
   end

   assign bus.led         = led_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.blinks_done = blinks_done_q;

endmodule
